eth_rx_pkt_buf: RTL and testbench
=================================

// Module: eth_rx_pkt_buf
// PURPOSE
//  Packet-mode RX buffer between the MAC receive datapath and the user-side pkt_rx_* read port.
//  - Stores complete frames from the RX datapath, which cannot be back-pressured.
//  - Asserts pkt_rx_avail while at least one complete frame is stored.
//  - Streams a frame out word by word under pkt_rx_ren.
//  - Drops whole frames on overflow or on a mid-frame abort.
// PARAMETERS
//  ADDR_W      9   log2 of buffer depth in 64-bit words (DEPTH = 2**ADDR_W)
//  DROP_CNT_W  16  width of the saturating dropped-frame counter
// PORTS
//  clk           in   1   single clock; all logic on posedge
//  rst           in   1   reset, asynchronous, active-low (0 = reset)
//  in_data       in   64  RX datapath word
//  in_val        in   1   in_* word valid this cycle
//  in_sop        in   1   first word of frame
//  in_eop        in   1   last word of frame
//  in_mod        in   3   valid bytes in eop word (0 = all 8)
//  in_err        in   1   frame error flag (CRC/len), qualified with in_eop
//  pkt_rx_ren    in   1   read enable from user
//  pkt_rx_avail  out  1   >=1 complete frame buffered
//  pkt_rx_data   out  64  read data
//  pkt_rx_val    out  1   pkt_rx_* valid this cycle
//  pkt_rx_sop    out  1   first word of frame
//  pkt_rx_eop    out  1   last word of frame
//  pkt_rx_mod    out  3   valid bytes in eop word
//  pkt_rx_err    out  1   frame error, valid with pkt_rx_eop
//  drop_cnt      out  DROP_CNT_W  frames dropped; saturates at all-ones
//  drop_pulse    out  1   one-cycle pulse per dropped frame
// BEHAVIOUR
//  Reset: all outputs 0; pointers and pkt_cnt 0; both FSMs idle; buffer contents discarded.
//  Pointers: wr_ptr, commit_ptr, rd_ptr are ADDR_W+1 bits. used = wr_ptr - rd_ptr. full = (used == DEPTH).
//  Write FSM {W_IDLE, W_FRAME, W_DISCARD}:
//   - W_IDLE: in_val & in_sop writes word -> W_FRAME. in_val without sop is ignored.
//   - W_FRAME: in_val writes at wr_ptr; wr_ptr+1.
//   - W_FRAME, in_val & in_eop: commit_ptr <= wr_ptr+1; pkt_cnt+1; -> W_IDLE.
//   - sop+eop in one word: written and committed in the same cycle.
//   - W_FRAME, in_val & in_sop (abort): wr_ptr <= commit_ptr; drop; new frame starts at commit_ptr.
//   - Write with full=1: wr_ptr <= commit_ptr; drop; -> W_DISCARD.
//   - W_DISCARD: ignore words until in_val & in_eop -> W_IDLE.
//   - W_DISCARD, in_val & in_sop without eop: start new frame -> W_FRAME.
//  Drop: drop_pulse=1 for 1 cycle; drop_cnt+1, saturating.
//  pkt_rx_avail = (pkt_cnt != 0), driven from a register.
//   - Rises in the cycle after the eop-write edge.
//  Read FSM {R_IDLE, R_FRAME}:
//   - Read issue in cycle N when ren & (R_FRAME | pkt_cnt!=0).
//   - Word at rd_ptr appears on pkt_rx_* in N+1 with pkt_rx_val=1 (1-cycle latency).
//   - rd_ptr+1 on each issue.
//   - Issued word sop -> R_FRAME. Issued word eop: pkt_cnt-1 -> R_IDLE.
//   - ren=0 mid-frame pauses: val=0 next cycle; data/sop/eop/mod/err hold their last value.
//   - ren with R_IDLE & pkt_cnt==0 is ignored; val=0.
//   - ren held after eop: next frame's sop issues the following cycle, with no bubble.
//  Simultaneous commit and eop-issue: pkt_cnt unchanged; avail stays 1.
//  Reads never pass commit_ptr; uncommitted words are never visible.
//  RAM write-to-read hazard: none, because commit is one edge after the last word is written.
//  Reset mid-operation: immediate clear; a partially read or written frame is lost; drop_cnt not incremented.
// STRUCTURE
//  Package eth_pkt_pkg:
//   - pkt_word_t: packed {data[63:0], sop, eop, mod[2:0], err}, 70 bits.
//   - wr_state_t, rd_state_t enums.
//   - MOD_ALL = 3'd0.
//  Sub-module eth_rx_pkt_ram:
//   - simple dual-port RAM, DEPTH x pkt_word_t, registered read, no reset on the array.
//  Top holds both FSMs, the pointers, pkt_cnt and the drop counter.
// TESTING (bench ADDR_W=4 unless noted)
//  1 3-word frame, mod=5, ren held 5 cycles:
//    avail=1 after eop; val 3 cycles; sop on word0; eop+mod=5 on word2; avail=0 after.
//  2 Two 2-word frames buffered, ren constant:
//    4 consecutive val cycles; eop then sop in adjacent cycles.
//  3 20-word frame into empty 16-deep buffer:
//    frame dropped; drop_pulse once; drop_cnt=1; avail=0.
//    A following 2-word frame reads back intact.
//  4 sop after 2 words of frame A, then 3-word frame B:
//    drop_cnt=1; only B read back with correct sop/eop.
//  5 ren toggled 1/0 during a 6-word frame:
//    val follows ren by one cycle; data order A0..A5 preserved; err=1 on eop if in_err=1.
//  6 rst=0 mid-read and again during a write:
//    all outputs 0 at once; avail=0; the next frame after release reads correctly.

Source files
------------

// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the packet-mode RX buffer.
package eth_pkt_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned MOD_W  = 3;

  // mod value meaning "all 8 bytes of the eop word are valid"
  localparam logic [MOD_W-1:0] MOD_ALL = 3'd0;

  // One stored buffer word: payload plus framing sideband (70 bits)
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic              err;
  } pkt_word_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_FRAME   = 2'd1,
    W_DISCARD = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_FRAME = 1'b1
  } rd_state_t;

endpackage

// File: rtl/eth_rx_pkt_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// A 1-bit eop sidecar is readable combinationally so the read FSM can
// tell, in the issue cycle, whether the word being issued ends a frame.
module eth_rx_pkt_ram
  import eth_pkt_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  pkt_word_t         i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output pkt_word_t         o_rdata,
  output logic              o_rd_eop_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  pkt_word_t r_mem     [DEPTH];
  logic      r_eop_mem [DEPTH];

  // Array write; contents are not reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr]     <= i_wdata;
      r_eop_mem[i_waddr] <= i_wdata.eop;
    end
  end

  // Registered read; holds its value when no read is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rd_eop_c = r_eop_mem[i_raddr];

endmodule

// File: rtl/eth_rx_pkt_buf.sv
// Packet-mode RX buffer: stores complete frames from a non-stallable MAC
// receive path and streams them out under pkt_rx_ren. Frames that overflow
// or are aborted mid-way are dropped whole and counted.
module eth_rx_pkt_buf
  import eth_pkt_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           in_data,
  input  logic                  in_val,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [2:0]            in_mod,
  input  logic                  in_err,
  input  logic                  pkt_rx_ren,
  output logic                  pkt_rx_avail,
  output logic [63:0]           pkt_rx_data,
  output logic                  pkt_rx_val,
  output logic                  pkt_rx_sop,
  output logic                  pkt_rx_eop,
  output logic [2:0]            pkt_rx_mod,
  output logic                  pkt_rx_err,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  drop_pulse
);

  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  wr_state_t             r_wr_state, w_wr_state_nxt;
  rd_state_t             r_rd_state, w_rd_state_nxt;
  logic [PTR_W-1:0]      r_wr_ptr, w_wr_ptr_nxt;
  logic [PTR_W-1:0]      r_commit_ptr, w_commit_ptr_nxt;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_pkt_cnt, w_pkt_cnt_nxt;
  logic                  r_avail;
  logic                  r_val;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  r_drop_pulse;

  logic             w_full;
  logic             w_commit_room;
  logic             w_we;
  logic [PTR_W-1:0] w_waddr;
  logic             w_commit;
  logic             w_drop;
  logic             w_issue;
  logic             w_dec;
  logic             w_rd_eop_c;
  pkt_word_t        w_wdata;
  pkt_word_t        w_rdata;

  // Occupancy seen by the writer; read side frees space as soon as it issues
  assign w_full        = ((r_wr_ptr - r_rd_ptr) == DEPTH_P);
  assign w_commit_room = ((r_commit_ptr - r_rd_ptr) != DEPTH_P);

  assign w_wdata.data = in_data;
  assign w_wdata.sop  = in_sop;
  assign w_wdata.eop  = in_eop;
  assign w_wdata.mod  = in_mod;
  assign w_wdata.err  = in_err;

  // Write FSM: frame accept, commit on eop, rewind-and-drop on overflow/abort
  always_comb begin
    w_wr_state_nxt   = r_wr_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_we             = 1'b0;
    w_waddr          = r_wr_ptr;
    w_commit         = 1'b0;
    w_drop           = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (in_val && in_sop) begin
          if (w_full) begin
            w_drop         = 1'b1;
            w_wr_ptr_nxt   = r_commit_ptr;
            w_wr_state_nxt = in_eop ? W_IDLE : W_DISCARD;
          end else begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ONE_P;
            if (in_eop) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_wr_ptr + ONE_P;
            end else begin
              w_wr_state_nxt = W_FRAME;
            end
          end
        end
      end
      W_FRAME: begin
        if (in_val && in_sop) begin
          // Abort: discard the open frame and restart at the commit point
          w_drop  = 1'b1;
          w_waddr = r_commit_ptr;
          if (!w_commit_room) begin
            w_wr_ptr_nxt   = r_commit_ptr;
            w_wr_state_nxt = in_eop ? W_IDLE : W_DISCARD;
          end else begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_commit_ptr + ONE_P;
            if (in_eop) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_commit_ptr + ONE_P;
              w_wr_state_nxt   = W_IDLE;
            end
          end
        end else if (in_val) begin
          if (w_full) begin
            w_drop         = 1'b1;
            w_wr_ptr_nxt   = r_commit_ptr;
            w_wr_state_nxt = in_eop ? W_IDLE : W_DISCARD;
          end else begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ONE_P;
            if (in_eop) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_wr_ptr + ONE_P;
              w_wr_state_nxt   = W_IDLE;
            end
          end
        end
      end
      W_DISCARD: begin
        if (in_val && in_eop) begin
          w_wr_state_nxt = W_IDLE;
        end else if (in_val && in_sop) begin
          if (w_full) begin
            w_drop = 1'b1;
          end else begin
            w_we           = 1'b1;
            w_wr_ptr_nxt   = r_wr_ptr + ONE_P;
            w_wr_state_nxt = W_FRAME;
          end
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Read issue only within a frame or when a committed frame is waiting
  assign w_issue = pkt_rx_ren && ((r_rd_state == R_FRAME) || (r_pkt_cnt != '0));
  assign w_dec   = w_issue && w_rd_eop_c;

  // Read FSM next state and committed-frame count
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_pkt_cnt_nxt  = r_pkt_cnt;
    if (w_issue) begin
      w_rd_state_nxt = w_rd_eop_c ? R_IDLE : R_FRAME;
    end
    if (w_commit && !w_dec) begin
      w_pkt_cnt_nxt = r_pkt_cnt + ONE_P;
    end else if (!w_commit && w_dec) begin
      w_pkt_cnt_nxt = r_pkt_cnt - ONE_P;
    end
  end

  // State, pointers, counters and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_state   <= W_IDLE;
      r_rd_state   <= R_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_cnt    <= '0;
      r_avail      <= 1'b0;
      r_val        <= 1'b0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_wr_state   <= w_wr_state_nxt;
      r_rd_state   <= w_rd_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ONE_P;
      end
      r_pkt_cnt    <= w_pkt_cnt_nxt;
      r_avail      <= (w_pkt_cnt_nxt != '0);
      r_val        <= w_issue;
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  eth_rx_pkt_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_waddr[ADDR_W-1:0]),
    .i_wdata    (w_wdata),
    .i_re       (w_issue),
    .i_raddr    (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata    (w_rdata),
    .o_rd_eop_c (w_rd_eop_c)
  );

  assign pkt_rx_avail = r_avail;
  assign pkt_rx_val   = r_val;
  assign pkt_rx_data  = w_rdata.data;
  assign pkt_rx_sop   = w_rdata.sop;
  assign pkt_rx_eop   = w_rdata.eop;
  assign pkt_rx_mod   = w_rdata.mod;
  assign pkt_rx_err   = w_rdata.err;
  assign drop_cnt     = r_drop_cnt;
  assign drop_pulse   = r_drop_pulse;

endmodule

// File: tb/tb_eth_rx_pkt_buf.sv
// Bench for eth_rx_pkt_buf: table of single-frame vectors plus directed
// multi-cycle sequences; read data is checked against a queue of words
// pushed as frames are driven.
`timescale 1ns/1ps
module tb_eth_rx_pkt_buf;
  import eth_pkt_pkg::*;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DROP_CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [63:0]           in_data = '0;
  logic                  in_val = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [2:0]            in_mod = '0;
  logic                  pkt_rx_ren = 1'b0;
  logic                  pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
  logic [63:0]           pkt_rx_data;
  logic [2:0]            pkt_rx_mod;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  drop_pulse;

  eth_rx_pkt_buf #(.ADDR_W(ADDR_W), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop),
    .in_mod(in_mod), .in_err(in_err), .pkt_rx_ren(pkt_rx_ren),
    .pkt_rx_avail(pkt_rx_avail), .pkt_rx_data(pkt_rx_data), .pkt_rx_val(pkt_rx_val),
    .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop), .pkt_rx_mod(pkt_rx_mod),
    .pkt_rx_err(pkt_rx_err), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_val_seen = 0;
  int n_drop_pulse = 0;
  int exp_drop = 0;

  pkt_word_t exp_q[$];
  pkt_word_t mon_e;

  logic        rec_val  [0:63];
  logic        rec_sop  [0:63];
  logic        rec_eop  [0:63];
  logic [63:0] rec_data [0:63];

  typedef struct {
    int         len;
    logic [2:0] mod;
    logic       err;
    int         ren_cyc;
    int         exp_val;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mkdata(input int id, input int i);
    return {8'hD0, 8'(id), 16'(i), 32'(id * 32'h9E37_79B1 + i * 32'h0101_0101)};
  endfunction

  // Read-side scoreboard and drop-pulse counter
  always @(negedge clk) begin
    if (drop_pulse) n_drop_pulse++;
    if (pkt_rx_val) begin
      n_val_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rd_unexpected: got word 0x%0h with no frame expected at %0t", pkt_rx_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", pkt_rx_data, mon_e.data);
        check("rd_sop",  64'(pkt_rx_sop), 64'(mon_e.sop));
        check("rd_eop",  64'(pkt_rx_eop), 64'(mon_e.eop));
        check("rd_mod",  64'(pkt_rx_mod), 64'(mon_e.mod));
        check("rd_err",  64'(pkt_rx_err), 64'(mon_e.err));
      end
    end
  end

  task automatic set_idle();
    in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = '0; in_err = 1'b0; in_data = '0;
  endtask

  task automatic drive_word(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] m, input logic er);
    @(negedge clk);
    in_val = 1'b1; in_data = d; in_sop = s; in_eop = e; in_mod = m; in_err = er;
  endtask

  task automatic send_frame(input int id, input int len, input logic [2:0] m,
                            input logic er, input logic keep);
    pkt_word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = mkdata(id, i);
      w.sop  = (i == 0);
      w.eop  = (i == len - 1);
      w.mod  = w.eop ? m : MOD_ALL;
      w.err  = w.eop ? er : 1'b0;
      drive_word(w.data, w.sop, w.eop, w.mod, w.err);
      if (keep) exp_q.push_back(w);
    end
    @(negedge clk);
    set_idle();
  endtask

  // rec_*[c] holds outputs produced by the ren value driven at step c-1
  task automatic run_read(input int n, input logic [63:0] pat);
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      rec_val[c]  = pkt_rx_val;
      rec_sop[c]  = pkt_rx_sop;
      rec_eop[c]  = pkt_rx_eop;
      rec_data[c] = pkt_rx_data;
      pkt_rx_ren  = (c < n) ? pat[c] : 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_val"},   64'(pkt_rx_val),   64'd0);
    check({tag, "_avail"}, 64'(pkt_rx_avail), 64'd0);
    check({tag, "_data"},  pkt_rx_data,       64'd0);
    check({tag, "_sop"},   64'(pkt_rx_sop),   64'd0);
    check({tag, "_eop"},   64'(pkt_rx_eop),   64'd0);
    check({tag, "_mod"},   64'(pkt_rx_mod),   64'd0);
    check({tag, "_err"},   64'(pkt_rx_err),   64'd0);
    check({tag, "_dcnt"},  64'(drop_cnt),     64'd0);
    check({tag, "_dpls"},  64'(drop_pulse),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    int          v0;
    int          p0;
    logic [63:0] ones;
    logic [63:0] pat5;

    vecs[0] = '{len: 3,  mod: 3'd5, err: 1'b0, ren_cyc: 5,  exp_val: 3};
    vecs[1] = '{len: 1,  mod: 3'd0, err: 1'b0, ren_cyc: 3,  exp_val: 1};
    vecs[2] = '{len: 4,  mod: 3'd7, err: 1'b1, ren_cyc: 4,  exp_val: 4};
    vecs[3] = '{len: 16, mod: 3'd2, err: 1'b0, ren_cyc: 18, exp_val: 16};
    vecs[4] = '{len: 6,  mod: 3'd1, err: 1'b1, ren_cyc: 8,  exp_val: 6};
    ones = '1;
    pat5 = 64'h555;

    // Reset state
    set_idle();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single frames: buffer, check avail, read out with ren held
    for (int k = 0; k < 5; k++) begin
      v0 = n_val_seen;
      send_frame(k + 1, vecs[k].len, vecs[k].mod, vecs[k].err, 1'b1);
      check("tbl_avail_set", 64'(pkt_rx_avail), 64'd1);
      check("tbl_val_idle",  64'(pkt_rx_val),   64'd0);
      run_read(vecs[k].ren_cyc, ones);
      check("tbl_first_val", 64'(rec_val[1]), 64'd1);
      check("tbl_val_after", 64'(rec_val[vecs[k].len + 1]), 64'd0);
      check("tbl_val_count", 64'(n_val_seen - v0), 64'(vecs[k].exp_val));
      check("tbl_avail_clr", 64'(pkt_rx_avail), 64'd0);
      check("tbl_q_empty",   64'(exp_q.size()), 64'd0);
      check("tbl_drop_cnt",  64'(drop_cnt), 64'(exp_drop));
    end

    // Two 2-word frames read back-to-back with no bubble
    send_frame(20, 2, 3'd3, 1'b0, 1'b1);
    send_frame(21, 2, 3'd4, 1'b1, 1'b1);
    check("t2_avail", 64'(pkt_rx_avail), 64'd1);
    run_read(6, ones);
    for (int c = 1; c <= 4; c++) check("t2_val_run", 64'(rec_val[c]), 64'd1);
    check("t2_val_end", 64'(rec_val[5]), 64'd0);
    check("t2_eop_w1",  64'(rec_eop[2]), 64'd1);
    check("t2_sop_w2",  64'(rec_sop[3]), 64'd1);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Oversized frame is dropped whole; following frame intact
    p0 = n_drop_pulse;
    send_frame(30, 20, 3'd3, 1'b0, 1'b0);
    exp_drop++;
    @(negedge clk);
    check("t3_pulse_once", 64'(n_drop_pulse - p0), 64'd1);
    check("t3_drop_cnt",   64'(drop_cnt), 64'(exp_drop));
    check("t3_avail",      64'(pkt_rx_avail), 64'd0);
    send_frame(31, 2, 3'd4, 1'b0, 1'b1);
    run_read(4, ones);
    check("t3_q_empty",    64'(exp_q.size()), 64'd0);
    check("t3_avail_clr",  64'(pkt_rx_avail), 64'd0);

    // Abort: sop arrives two words into frame A
    v0 = n_val_seen;
    drive_word(mkdata(40, 0), 1'b1, 1'b0, 3'd0, 1'b0);
    drive_word(mkdata(40, 1), 1'b0, 1'b0, 3'd0, 1'b0);
    send_frame(41, 3, 3'd6, 1'b0, 1'b1);
    exp_drop++;
    check("t4_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("t4_avail",    64'(pkt_rx_avail), 64'd1);
    run_read(5, ones);
    check("t4_val_count", 64'(n_val_seen - v0), 64'd3);
    check("t4_q_empty",   64'(exp_q.size()), 64'd0);

    // ren toggling mid-frame: val tracks ren one cycle later, data holds
    send_frame(50, 6, 3'd2, 1'b1, 1'b1);
    run_read(12, pat5);
    for (int c = 1; c <= 12; c++) begin
      check("t5_val_follow", 64'(rec_val[c]), 64'(pat5[c-1]));
      if (!rec_val[c] && c >= 2) check("t5_data_hold", rec_data[c], rec_data[c-1]);
    end
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-read
    send_frame(60, 6, 3'd0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      pkt_rx_ren = 1'b1;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_rd");
    exp_q.delete();
    exp_drop = 0;
    pkt_rx_ren = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-write
    drive_word(mkdata(61, 0), 1'b1, 1'b0, 3'd0, 1'b0);
    drive_word(mkdata(61, 1), 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    set_idle();
    #1 check_reset_outputs("rst_wr");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_avail_after", 64'(pkt_rx_avail), 64'd0);
    v0 = n_val_seen;
    send_frame(62, 3, 3'd1, 1'b1, 1'b1);
    check("t6_avail_new", 64'(pkt_rx_avail), 64'd1);
    run_read(5, ones);
    check("t6_val_count", 64'(n_val_seen - v0), 64'd3);
    check("t6_q_empty",   64'(exp_q.size()), 64'd0);
    check("t6_drop_cnt",  64'(drop_cnt), 64'(exp_drop));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
